// File: rtl/test_pkg.sv
// Shared definitions for the vector runner: FSM state encoding and the
// width of the latency wait counter.
package test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Wide enough for the largest supported DUT latency of 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that paces the WAIT state of vec_runner.
// zero_next is high when the decrement in the current cycle reaches zero.
module wait_counter
  import test_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_next
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_next = (count_q <= CNT_W'(1));

endmodule

// File: rtl/vec_runner.sv
// Steps through DEPTH ROM vectors, drives each to a DUT with latency LAT,
// compares the response and reports error count, first failing index and pass.
module vec_runner
  import test_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int DW    = 32,
  parameter  int LAT   = 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int EW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          finish,
  output logic [AW-1:0] vec_addr,
  input  logic [DW-1:0] vec_stim,
  input  logic [DW-1:0] vec_exp,
  output logic [DW-1:0] dut_in,
  output logic          dut_valid,
  input  logic [DW-1:0] dut_out,
  output logic [EW-1:0] err_cnt,
  output logic          pass,
  output logic [AW-1:0] fail_idx,
  output logic          fail_valid,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [AW-1:0] vec_addr_q, vec_addr_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0] fail_idx_q, fail_idx_d;
  logic          fail_valid_q, fail_valid_d;
  logic          cnt_load, cnt_dec, cnt_zero_next;

  wait_counter u_wait_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_val  (CNT_W'(LAT)),
    .dec       (cnt_dec),
    .zero_next (cnt_zero_next)
  );

  always_comb begin
    state_d      = state_q;
    vec_addr_d   = vec_addr_q;
    err_cnt_d    = err_cnt_q;
    fail_idx_d   = fail_idx_q;
    fail_valid_d = fail_valid_q;
    cnt_load     = (state_q == ST_APPLY);
    cnt_dec      = (state_q == ST_WAIT);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_APPLY;
          vec_addr_d = '0;
        end
      end
      ST_APPLY: begin
        state_d = (LAT > 0) ? ST_WAIT : ST_CHECK;
      end
      ST_WAIT: begin
        if (cnt_zero_next) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (dut_out != vec_exp) begin
          err_cnt_d = err_cnt_q + EW'(1);
          if (!fail_valid_q) begin
            fail_idx_d   = vec_addr_q;
            fail_valid_d = 1'b1;
          end
        end
        if (vec_addr_q == AW'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          vec_addr_d = vec_addr_q + AW'(1);
          state_d    = ST_APPLY;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_addr_q   <= '0;
      err_cnt_q    <= '0;
      fail_idx_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_addr_q   <= vec_addr_d;
      err_cnt_q    <= err_cnt_d;
      fail_idx_q   <= fail_idx_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  // The ROM is read combinationally from the registered address, so the
  // stimulus is simply gated by the registered APPLY state.
  assign dut_valid  = (state_q == ST_APPLY);
  assign dut_in     = dut_valid ? vec_stim : '0;
  assign finish     = (state_q == ST_DONE);
  assign pass       = (state_q == ST_DONE) && (err_cnt_q == '0);
  assign busy       = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign vec_addr   = vec_addr_q;
  assign err_cnt    = err_cnt_q;
  assign fail_idx   = fail_idx_q;
  assign fail_valid = fail_valid_q;

endmodule
